mem_sram_controller: RTL and testbench
======================================

MEM_SRAM_CONTROLLER -- requirements
Module: mem_sram_controller

Interface
REQ-001 SHALL provide parameter ACCESS_CYCLES, default 3, clock cycles per 16-bit SRAM half-access, legal range 1..15.
REQ-002 SHALL provide parameter BASE_ADDR, default 1024, data-memory byte address that maps to SRAM word 0.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_read_en  input  1  load request from the EXE/MEM register.
REQ-006 SHALL have port mem_write_en  input  1  store request from the EXE/MEM register.
REQ-007 SHALL have port address  input  32  byte address, i.e. the ALU result.
REQ-008 SHALL have port write_data  input  32  store data, i.e. the forwarded Rm value.
REQ-009 SHALL have port read_data  output  32  registered load result.
REQ-010 SHALL have port ready  output  1  access complete this cycle.
REQ-011 SHALL have port freeze  output  1  pipeline stall request to the PC, IF/ID, ID/EXE and EXE/MEM registers.
REQ-012 SHALL have port sram_addr  output  18  SRAM half-word address.
REQ-013 SHALL have port sram_dq_out  output  16  SRAM write data.
REQ-014 SHALL have port sram_dq_in  input  16  SRAM read data.
REQ-015 SHALL have port sram_dq_oe  output  1  1 = controller drives the SRAM data bus.
REQ-016 SHALL have port sram_we_n  output  1  active-low SRAM write strobe.

Function
REQ-017 SHALL implement states IDLE, LOW, HIGH and DONE, plus a 4-bit phase counter cnt.
REQ-018 In IDLE with a request (mem_read_en or mem_write_en), SHALL capture address, write_data and is_write (is_write = mem_write_en), clear cnt and go to LOW; with no request, SHALL stay in IDLE.
REQ-019 If mem_read_en and mem_write_en are both 1, SHALL perform a write and leave read_data unchanged.
REQ-020 SHALL compute word_idx = (captured address - BASE_ADDR) bits [18:2], modulo 2^32; address bits [1:0] are ignored.
REQ-021 In LOW, SHALL drive sram_addr = {word_idx[16:0],0} and sram_dq_out = data[15:0].
REQ-022 In HIGH, SHALL drive sram_addr = {word_idx[16:0],1} and sram_dq_out = data[31:16].
REQ-023 SHALL drive every SRAM output from registered state only, with no combinational path from the request inputs.
REQ-024 Each of LOW and HIGH SHALL last exactly ACCESS_CYCLES cycles: cnt increments each cycle, and the state advances when cnt = ACCESS_CYCLES-1, clearing cnt.
REQ-025 For writes, sram_we_n and sram_dq_oe SHALL be 0 and 1 respectively throughout LOW and HIGH; for reads, and in all other states, they SHALL be 1 and 0.
REQ-026 For reads, SHALL load read_data[15:0] from sram_dq_in on the last LOW cycle and read_data[31:16] on the last HIGH cycle.
REQ-027 DONE SHALL last one cycle with ready = 1 and read_data holding the complete word, then go to IDLE unconditionally.
REQ-028 freeze SHALL equal (mem_read_en or mem_write_en) and (state != DONE), combinationally, so the request is frozen in place until DONE.
REQ-029 Latency: for a request first seen in cycle 0, ready SHALL assert in cycle 2*ACCESS_CYCLES+1, with freeze = 1 in cycles 0..2*ACCESS_CYCLES.
REQ-030 Once LOW has been entered, the access SHALL complete even if the request inputs deassert, so no torn writes occur; freeze then follows REQ-028.
REQ-031 Back-to-back requests: IDLE is re-entered after DONE, and the next request is captured there, one cycle after ready.
REQ-032 read_data SHALL hold its value between reads and SHALL NOT change on writes.

Reset
REQ-033 rst = 0 SHALL, asynchronously and at any time including mid-access, force state to IDLE, cnt to 0, read_data to 0, ready to 0, sram_addr to 0, sram_dq_out to 0, sram_dq_oe to 0 and sram_we_n to 1.
REQ-034 A write interrupted by reset SHALL NOT be resumed after reset releases.

Verification
REQ-035 Write: address = 1032, write_data = 0xDEADBEEF, ACCESS_CYCLES = 3 -> sram_addr = 4 with 0xBEEF for 3 cycles, then 5 with 0xDEAD for 3 cycles, sram_we_n = 0 for 6 cycles, ready in cycle 7, freeze high in cycles 0..6.
REQ-036 Read back address 1032 with an SRAM model -> read_data = 0xDEADBEEF in cycle 7, sram_we_n = 1 throughout.
REQ-037 Both enables high, address 1024, data 0x12345678 -> write performed, read_data unchanged.
REQ-038 Request dropped in cycle 2 of a write -> both halves still written, ready in cycle 7, freeze low from cycle 2.
REQ-039 rst pulsed low during HIGH -> all outputs at reset values immediately, IDLE after release, second half not written.
REQ-040 ACCESS_CYCLES = 1, two back-to-back reads -> ready in cycles 3 and 7.

Source files
------------

// File: rtl/mem_sram_controller_if.sv
// Bus bundle between the pipeline MEM stage, the SRAM controller and the
// external 16-bit SRAM.
interface mem_sram_controller_if;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    modport slave (
        input  mem_read_en, mem_write_en, address, write_data, sram_dq_in,
        output read_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output mem_read_en, mem_write_en, address, write_data, sram_dq_in,
        input  read_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/mem_sram_controller.sv
// Splits each 32-bit pipeline load/store into two timed 16-bit SRAM accesses
// and stalls the pipeline until the word is complete.
//
// state  | meaning
// IDLE   | waiting for a request; captures address/data/direction
// LOW    | low half-word access, ACCESS_CYCLES cycles
// HIGH   | high half-word access, ACCESS_CYCLES cycles
// DONE   | one-cycle completion, ready = 1
module mem_sram_controller #(
    parameter int unsigned ACCESS_CYCLES = 3,
    parameter int unsigned BASE_ADDR     = 1024
) (
    input  logic               clk,
    input  logic               rst,
    mem_sram_controller_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] word_q, word_d;
    logic [31:0] data_q, data_d;
    logic        is_write_q, is_write_d;
    logic [31:0] read_data_q, read_data_d;

    logic        req;
    logic        last;
    logic        in_access;
    logic [16:0] word_idx;

    assign req      = bus.mem_read_en | bus.mem_write_en;
    assign last     = (cnt_q == LAST_CNT);
    assign word_idx = 17'((bus.address - 32'(BASE_ADDR)) >> 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            word_q      <= 17'd0;
            data_q      <= 32'd0;
            is_write_q  <= 1'b0;
            read_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            data_q      <= data_d;
            is_write_q  <= is_write_d;
            read_data_q <= read_data_d;
        end
    end

    // Once LOW is entered the access runs to completion regardless of req.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        data_d      = data_q;
        is_write_d  = is_write_q;
        read_data_d = read_data_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    word_d     = word_idx;
                    data_d     = bus.write_data;
                    is_write_d = bus.mem_write_en;
                    cnt_d      = 4'd0;
                    state_d    = S_LOW;
                end
            end
            S_LOW: begin
                if (last) begin
                    cnt_d   = 4'd0;
                    state_d = S_HIGH;
                    if (!is_write_q) read_data_d[15:0] = bus.sram_dq_in;
                end else begin
                    cnt_d = 4'(cnt_q + 4'd1);
                end
            end
            S_HIGH: begin
                if (last) begin
                    cnt_d   = 4'd0;
                    state_d = S_DONE;
                    if (!is_write_q) read_data_d[31:16] = bus.sram_dq_in;
                end else begin
                    cnt_d = 4'(cnt_q + 4'd1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // SRAM pins decode from registered state only, so reset clears them at once.
    assign in_access       = (state_q == S_LOW) || (state_q == S_HIGH);
    assign bus.sram_addr   = in_access ? {word_q, state_q == S_HIGH} : 18'd0;
    assign bus.sram_dq_out = (state_q == S_LOW)  ? data_q[15:0]  :
                             (state_q == S_HIGH) ? data_q[31:16] : 16'd0;
    assign bus.sram_dq_oe  = in_access & is_write_q;
    assign bus.sram_we_n   = ~(in_access & is_write_q);
    assign bus.ready       = (state_q == S_DONE);
    assign bus.freeze      = req & (state_q != S_DONE);
    assign bus.read_data   = read_data_q;
endmodule

// File: tb/tb_mem_sram_controller.sv
// Directed bench: writes, reads, dual-enable, dropped request, mid-access
// reset, and back-to-back reads with single-cycle half accesses.
module tb_mem_sram_controller;
    logic clk;
    logic rst;
    logic mem_clr;
    int   n_chk;
    int   n_pass;

    mem_sram_controller_if busa ();
    mem_sram_controller_if busb ();

    mem_sram_controller #(.ACCESS_CYCLES(3), .BASE_ADDR(1024)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (busa.slave)
    );

    mem_sram_controller #(.ACCESS_CYCLES(1), .BASE_ADDR(1024)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (busb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem_a [256];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_a[i] <= 16'h0;
        end else if (!busa.sram_we_n && busa.sram_dq_oe) begin
            mem_a[busa.sram_addr[7:0]] <= busa.sram_dq_out;
        end
    end

    assign busa.sram_dq_in = mem_a[busa.sram_addr[7:0]];
    // Second instance sees a fixed pattern: half-word address ORed into 0xA000.
    assign busb.sram_dq_in = 16'hA000 | busb.sram_addr[15:0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic access_a(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input int drop_at,
                            input logic [17:0] exp_lo, input logic [31:0] exp_rd);
        logic active, in_lo, in_hi;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                busa.mem_read_en  = rd;
                busa.mem_write_en = wr;
                busa.address      = addr;
                busa.write_data   = data;
            end
            if (c == drop_at) begin
                busa.mem_read_en  = 1'b0;
                busa.mem_write_en = 1'b0;
            end
            #1;
            active = (drop_at < 0) || (c < drop_at);
            in_lo  = (c >= 1) && (c <= 3);
            in_hi  = (c >= 4) && (c <= 6);
            chk("freeze", 32'(busa.freeze), 32'(active && (c != 7)));
            chk("ready", 32'(busa.ready), 32'(c == 7));
            chk("we_n", 32'(busa.sram_we_n), 32'(!(wr && (in_lo || in_hi))));
            chk("dq_oe", 32'(busa.sram_dq_oe), 32'(wr && (in_lo || in_hi)));
            chk("sram_addr", 32'(busa.sram_addr),
                in_lo ? 32'(exp_lo) : in_hi ? 32'(exp_lo) + 32'd1 : 32'd0);
            if (wr)
                chk("dq_out", 32'(busa.sram_dq_out),
                    in_lo ? 32'(data[15:0]) : in_hi ? 32'(data[31:16]) : 32'd0);
            if (c == 7) begin
                chk("read_data", busa.read_data, exp_rd);
                busa.mem_read_en  = 1'b0;
                busa.mem_write_en = 1'b0;
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b0;
        mem_clr = 1'b1;
        busa.mem_read_en = 1'b0; busa.mem_write_en = 1'b0;
        busa.address = 32'd0;    busa.write_data = 32'd0;
        busb.mem_read_en = 1'b0; busb.mem_write_en = 1'b0;
        busb.address = 32'd0;    busb.write_data = 32'd0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_read_data", busa.read_data, 32'd0);
        chk("rst_ready", 32'(busa.ready), 32'd0);
        chk("rst_sram_addr", 32'(busa.sram_addr), 32'd0);
        chk("rst_dq_out", 32'(busa.sram_dq_out), 32'd0);
        chk("rst_dq_oe", 32'(busa.sram_dq_oe), 32'd0);
        chk("rst_we_n", 32'(busa.sram_we_n), 32'd1);
        chk("rst_freeze", 32'(busa.freeze), 32'd0);
        mem_clr = 1'b0;
        rst = 1'b1;

        // Write 0xDEADBEEF to 1032 -> half-words 4 and 5
        access_a(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, -1, 18'd4, 32'h0);
        chk("mem4", 32'(mem_a[4]), 32'h0000BEEF);
        chk("mem5", 32'(mem_a[5]), 32'h0000DEAD);

        // Read it back
        access_a(1'b1, 1'b0, 32'd1032, 32'h0, -1, 18'd4, 32'hDEADBEEF);
        repeat (2) @(negedge clk);
        #1;
        chk("rd_hold", busa.read_data, 32'hDEADBEEF);

        // Both enables: write wins, read_data untouched
        access_a(1'b1, 1'b1, 32'd1024, 32'h12345678, -1, 18'd0, 32'hDEADBEEF);
        chk("mem0", 32'(mem_a[0]), 32'h00005678);
        chk("mem1", 32'(mem_a[1]), 32'h00001234);

        // Request dropped in cycle 2: write still completes
        access_a(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 2, 18'd8, 32'hDEADBEEF);
        chk("mem8", 32'(mem_a[8]), 32'h0000F00D);
        chk("mem9", 32'(mem_a[9]), 32'h0000CAFE);

        // Reset during HIGH of a write to 1048 -> half-words 12 and 13
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                busa.mem_write_en = 1'b1;
                busa.address      = 32'd1048;
                busa.write_data   = 32'hA5A55A5A;
            end
        end
        #1;
        chk("pre_rst_addr", 32'(busa.sram_addr), 32'd13);
        chk("pre_rst_we_n", 32'(busa.sram_we_n), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_addr", 32'(busa.sram_addr), 32'd0);
        chk("mid_rst_dq_out", 32'(busa.sram_dq_out), 32'd0);
        chk("mid_rst_dq_oe", 32'(busa.sram_dq_oe), 32'd0);
        chk("mid_rst_we_n", 32'(busa.sram_we_n), 32'd1);
        chk("mid_rst_ready", 32'(busa.ready), 32'd0);
        chk("mid_rst_read_data", busa.read_data, 32'd0);
        busa.mem_write_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            chk("post_rst_we_n", 32'(busa.sram_we_n), 32'd1);
            chk("post_rst_addr", 32'(busa.sram_addr), 32'd0);
        end
        chk("mem12", 32'(mem_a[12]), 32'h00005A5A);
        chk("mem13", 32'(mem_a[13]), 32'h00000000);

        // ACCESS_CYCLES = 1: back-to-back reads of 1024 then 1036
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                busb.mem_read_en = 1'b1;
                busb.address     = 32'd1024;
            end
            #1;
            chk("b_ready", 32'(busb.ready), 32'((c == 3) || (c == 7)));
            chk("b_we_n", 32'(busb.sram_we_n), 32'd1);
            if (c == 3) begin
                chk("b_rd0", busb.read_data, 32'hA001A000);
                busb.address = 32'd1036;
            end
            if (c == 5) chk("b_rd_hold", busb.read_data, 32'hA001A000);
            if (c == 7) begin
                chk("b_rd1", busb.read_data, 32'hA007A006);
                busb.mem_read_en = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
